lut_access_arbiter: RTL and testbench



---
 rtl/lut_arb_pkg.sv | 21 ++
 rtl/lut_access_arbiter_rr_arbiter.sv | 37 +++
 rtl/lut_access_arbiter.sv | 135 +++++++++++++
 tb/tb_lut_access_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lut_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : lut_arb_pkg
// Brief  : Shared types and default sizes for the lookup-table access arbiter.
// Rev    : 1.0
// ============================================================================
package lut_arb_pkg;

  localparam int LUT_NUM_RX = 4;
  localparam int LUT_ASIZE  = 8;
  localparam int LUT_DW     = 16;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef logic [LUT_DW-1:0] entry_t;

endpackage
`default_nettype wire

// File: rtl/lut_access_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick, searching upward from pointer+1.
// Rev    : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_pointer,
  input  logic          i_enable,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic [PW-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = PW'((int'(i_pointer) + k) % N);
      if (i_enable && !o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lut_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module : lut_access_arbiter
// Brief  : Clears the lookup table after reset, then shares its single port
//          between per-port VPI readers and one management writer.
// Rev    : 1.0
// ============================================================================
module lut_access_arbiter
  import lut_arb_pkg::*;
#(
  parameter int NUM_RX = LUT_NUM_RX,
  parameter int ASIZE  = LUT_ASIZE,
  parameter int DW     = LUT_DW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RX-1:0]       i_rd_req,
  input  logic [NUM_RX*ASIZE-1:0] i_rd_addr,
  output logic [NUM_RX-1:0]       o_rd_gnt,
  output logic [NUM_RX-1:0]       o_rd_valid,
  output logic [DW-1:0]           o_rd_data,
  input  logic                    i_wr_req,
  input  logic [ASIZE-1:0]        i_wr_addr,
  input  logic [DW-1:0]           i_wr_data,
  output logic                    o_wr_gnt,
  output logic [ASIZE-1:0]        o_mem_addr,
  output logic                    o_mem_we,
  output logic                    o_mem_re,
  output logic [DW-1:0]           o_mem_wdata,
  input  logic [DW-1:0]           i_mem_rdata,
  output logic                    o_init_done
);

  localparam int PW = (NUM_RX > 1) ? $clog2(NUM_RX) : 1;
  localparam logic [ASIZE-1:0] c_last_addr = '1;
  localparam logic [PW-1:0]    c_ptr_rst   = PW'(NUM_RX - 1);

  state_t              r_state;
  logic [ASIZE-1:0]    r_init_cnt;
  logic [PW-1:0]       r_ptr;
  logic                r_wr_last;
  logic [NUM_RX-1:0]   r_rd_valid;
  logic                r_init_done;

  logic                w_run;
  logic                w_wr_win;
  logic                w_rd_en;
  logic [NUM_RX-1:0]   w_arb_gnt;
  logic [PW-1:0]       w_arb_idx;
  logic                w_arb_any;
  logic [ASIZE-1:0]    w_rd_addr [NUM_RX];

  for (genvar gi = 0; gi < NUM_RX; gi++) begin : g_addr
    assign w_rd_addr[gi] = i_rd_addr[gi*ASIZE +: ASIZE];
  end

  // A write yields to pending reads on the cycle after it was granted.
  assign w_run    = (r_state == ST_RUN);
  assign w_wr_win = w_run && i_wr_req && !(r_wr_last && (|i_rd_req));
  assign w_rd_en  = w_run && !w_wr_win;

  rr_arbiter #(
    .N  (NUM_RX),
    .PW (PW)
  ) u_rr (
    .i_req     (i_rd_req),
    .i_pointer (r_ptr),
    .i_enable  (w_rd_en),
    .o_gnt     (w_arb_gnt),
    .o_idx     (w_arb_idx),
    .o_any     (w_arb_any)
  );

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_re    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_rd_gnt    = '0;
    o_wr_gnt    = 1'b0;
    if (rst) begin
      o_mem_we = 1'b1;
    end else if (!w_run) begin
      o_mem_we   = 1'b1;
      o_mem_addr = r_init_cnt;
    end else if (w_wr_win) begin
      o_wr_gnt    = 1'b1;
      o_mem_we    = 1'b1;
      o_mem_addr  = i_wr_addr;
      o_mem_wdata = i_wr_data;
    end else if (w_arb_any) begin
      o_rd_gnt   = w_arb_gnt;
      o_mem_re   = 1'b1;
      o_mem_addr = w_rd_addr[w_arb_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_ptr       <= c_ptr_rst;
      r_wr_last   <= 1'b0;
      r_rd_valid  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_rd_valid <= '0;
      r_wr_last  <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == c_last_addr) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_wr_win) begin
            r_wr_last <= 1'b1;
          end else if (w_arb_any) begin
            r_ptr      <= w_arb_idx;
            r_rd_valid <= w_arb_gnt;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = i_mem_rdata;
  assign o_init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_lut_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_lut_access_arbiter
// Brief  : Directed self-checking bench with a behavioural single-port table.
// Rev    : 1.0
// ============================================================================
module tb_lut_access_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  rd_req;
  logic [31:0] rd_addr;
  logic [3:0]  rd_gnt;
  logic [3:0]  rd_valid;
  logic [15:0] rd_data;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_gnt;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        init_done;

  logic [15:0] mem [256];
  int          n_checks = 0;
  int          n_errors = 0;

  lut_access_arbiter u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_rd_req    (rd_req),
    .i_rd_addr   (rd_addr),
    .o_rd_gnt    (rd_gnt),
    .o_rd_valid  (rd_valid),
    .o_rd_data   (rd_data),
    .i_wr_req    (wr_req),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .o_wr_gnt    (wr_gnt),
    .o_mem_addr  (mem_addr),
    .o_mem_we    (mem_we),
    .o_mem_re    (mem_re),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table model; preloaded with a non-zero pattern so the clear is visible.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
    mem_rdata = 16'h0;
  end
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_we"},    {31'd0, mem_we},    32'd1);
    check({tag, "_addr"},  {24'd0, mem_addr},  32'd0);
    check({tag, "_wdata"}, {16'd0, mem_wdata}, 32'd0);
    check({tag, "_re"},    {31'd0, mem_re},    32'd0);
    check({tag, "_rgnt"},  {28'd0, rd_gnt},    32'd0);
    check({tag, "_wgnt"},  {31'd0, wr_gnt},    32'd0);
    check({tag, "_rval"},  {28'd0, rd_valid},  32'd0);
    check({tag, "_done"},  {31'd0, init_done}, 32'd0);
  endtask

  // Entered just after reset release; returns inside the first RUN cycle.
  task automatic init_sweep(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (!(mem_we === 1'b1 && mem_addr === 8'(i) && mem_wdata === 16'h0 &&
            mem_re === 1'b0 && rd_gnt === 4'h0 && wr_gnt === 1'b0 &&
            init_done === 1'b0))
        bad++;
      @(negedge clk);
      #1;
    end
    check({tag, "_sweep_bad"}, 32'(bad), 32'd0);
    check({tag, "_done"}, {31'd0, init_done}, 32'd1);
  endtask

  task automatic set_addr(input int p, input logic [7:0] a);
    rd_addr[p*8 +: 8] = a;
  endtask

  initial begin
    int exp4 [6];
    int exp13 [4];
    exp4  = '{0, 1, 2, 3, 0, 1};
    exp13 = '{3, 1, 3, 1};

    rst = 1'b1; rd_req = '0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset("por");
    @(negedge clk);
    rst = 1'b0;
    #1;
    init_sweep("init0");
    check("run_idle_we", {31'd0, mem_we}, 32'd1 - 32'd1);

    // Read of a cleared entry
    @(negedge clk); rd_req = 4'b0001; set_addr(0, 8'h10); #1;
    check("clr_rd_gnt", {28'd0, rd_gnt}, 32'h1);
    check("clr_rd_maddr", {24'd0, mem_addr}, 32'h10);
    @(negedge clk); rd_req = '0; #1;
    check("clr_rd_valid", {28'd0, rd_valid}, 32'h1);
    check("clr_rd_data", {16'd0, rd_data}, 32'h0);

    // Write then read-after-write on port 2
    @(negedge clk); wr_req = 1'b1; wr_addr = 8'h10; wr_data = 16'hABCD; #1;
    check("raw_wgnt", {31'd0, wr_gnt}, 32'd1);
    check("raw_wdata", {16'd0, mem_wdata}, 32'hABCD);
    @(negedge clk); wr_req = 1'b0; rd_req = 4'b0100; set_addr(2, 8'h10); #1;
    check("raw_rgnt", {28'd0, rd_gnt}, 32'h4);
    @(negedge clk); rd_req = '0; #1;
    check("raw_rval", {28'd0, rd_valid}, 32'h4);
    check("raw_rdata", {16'd0, rd_data}, 32'hABCD);

    // Write alone is granted every cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); wr_req = 1'b1; wr_addr = 8'h20 + 8'(i); wr_data = 16'hC000 | 16'(i); #1;
      check("wr_burst_gnt", {31'd0, wr_gnt}, 32'd1);
    end

    // Single read on port 3 leaves the pointer at 3
    @(negedge clk); wr_req = 1'b0; rd_req = 4'b1000; set_addr(3, 8'h23); #1;
    check("p3_rgnt", {28'd0, rd_gnt}, 32'h8);
    @(negedge clk); rd_req = '0; #1;
    check("p3_rdata", {16'd0, rd_data}, 32'hC003);

    // All four requesting: 0,1,2,3,0,1 with pipelined responses
    for (int p = 0; p < 4; p++) set_addr(p, 8'h20 + 8'(p));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); rd_req = 4'b1111; #1;
      check("rr4_gnt", {28'd0, rd_gnt}, 32'd1 << exp4[c]);
      check("rr4_maddr", {24'd0, mem_addr}, 32'h20 + 32'(exp4[c]));
      if (c > 0) begin
        check("rr4_rval", {28'd0, rd_valid}, 32'd1 << exp4[c-1]);
        check("rr4_rdata", {16'd0, rd_data}, 32'hC000 | 32'(exp4[c-1]));
      end
    end
    @(negedge clk); rd_req = '0; #1;
    check("rr4_last_rval", {28'd0, rd_valid}, 32'h2);
    check("rr4_last_rdata", {16'd0, rd_data}, 32'hC001);

    // Write and port 1 held together alternate
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); wr_req = 1'b1; wr_addr = 8'h30; wr_data = 16'h5555; rd_req = 4'b0010; #1;
      check("alt_wgnt", {31'd0, wr_gnt}, (c % 2 == 0) ? 32'd1 : 32'd0);
      check("alt_rgnt", {28'd0, rd_gnt}, (c % 2 == 0) ? 32'd0 : 32'h2);
    end
    @(negedge clk); wr_req = 1'b0; rd_req = '0; #1;
    check("alt_rdata", {16'd0, rd_data}, 32'hC001);

    // Ports 1 and 3 with pointer at 1: 3, wrap to 1, 3, 1
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); rd_req = 4'b1010; #1;
      check("p13_gnt", {28'd0, rd_gnt}, 32'd1 << exp13[c]);
    end
    @(negedge clk); rd_req = '0; #1;
    check("p13_rdata", {16'd0, rd_data}, 32'hC001);

    // Reset one cycle after a read grant drops the pending response
    @(negedge clk); rd_req = 4'b0001; set_addr(0, 8'h20); #1;
    check("rstrd_gnt", {28'd0, rd_gnt}, 32'h1);
    @(negedge clk); rd_req = '0; #1;
    check("rstrd_pre_rval", {28'd0, rd_valid}, 32'h1);
    rst = 1'b1; #1;
    check_reset("rst_after_rd");
    @(posedge clk); #1;
    check("rst_hold_rval", {28'd0, rd_valid}, 32'h0);

    // Reset in the middle of INIT restarts the clear from address 0
    @(negedge clk); rst = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    check("mid_init_addr", {24'd0, mem_addr}, 32'd100);
    check("mid_init_we", {31'd0, mem_we}, 32'd1);
    rst = 1'b1; #1;
    check_reset("rst_mid_init");
    @(negedge clk); rst = 1'b0; wr_req = 1'b1; wr_addr = 8'h40; wr_data = 16'h1234;
    rd_req = 4'b1000; set_addr(3, 8'h40); #1;
    init_sweep("init2");
    check("post_init_wgnt", {31'd0, wr_gnt}, 32'd1);
    @(negedge clk); #1;
    check("post_init_rgnt", {28'd0, rd_gnt}, 32'h8);
    @(negedge clk); wr_req = 1'b0; rd_req = '0; #1;
    check("post_init_rdata", {16'd0, rd_data}, 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
